// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter and the
// processor integration that instantiates it.
package mem_arb_pkg;

   typedef enum logic {
      FREE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam int XLEN_DEF  = 64;
   localparam int N_REQ_DEF = 2;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: packed per-requester
// request/command lanes and the shared read-data return.
interface data_memory_arbiter_if #(
   parameter int xlen  = 64,
   parameter int n_req = 2
);
   logic [n_req-1:0]      req;
   logic [n_req-1:0]      we;
   logic [n_req-1:0]      lock;
   logic [n_req*xlen-1:0] addr;
   logic [n_req*xlen-1:0] wdata;
   logic [n_req-1:0]      gnt;
   logic [n_req-1:0]      stall;
   logic [n_req-1:0]      rvalid;
   logic [xlen-1:0]       rdata;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, stall, rvalid, rdata
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, stall, rvalid, rdata
   );
endinterface

// File: rtl/data_memory_arbiter_rr_picker.sv
// Combinational round-robin select: one-hot grant to the first request at
// or above ptr, wrapping modulo n.
module rr_picker #(
   parameter int n     = 2,
   parameter int ptr_w = (n > 1) ? $clog2(n) : 1
) (
   input  logic [n-1:0]     req,
   input  logic [ptr_w-1:0] ptr,
   output logic [n-1:0]     gnt
);

   int   idx;
   logic found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < n; off++) begin
         idx = int'(ptr) + off;
         if (idx >= n) idx = idx - n;
         for (int j = 0; j < n; j++) begin
            if (!found && (j == idx) && req[j]) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Single-port data memory arbiter: round-robin between requesters with an
// optional burst lock, registered read return and saturating grant counters.
//
// state  | meaning
// FREE   | no owner; round-robin search from rr_ptr
// LOCKED | owner_q keeps the memory while its req stays high
module data_memory_arbiter
   import mem_arb_pkg::*;
#(
   parameter int xlen  = XLEN_DEF,
   parameter int n_req = N_REQ_DEF,
   parameter int cnt_w = 32
) (
   input  logic                     clk,
   input  logic                     rstn,
   data_memory_arbiter_if.slave     bus,
   output logic [n_req*cnt_w-1:0]   grant_count,
   output logic                     mem_read_en,
   output logic                     mem_write_en,
   output logic [xlen-1:0]          mem_address,
   output logic [xlen-1:0]          mem_write_data,
   input  logic [xlen-1:0]          mem_read_data
);

   localparam int ptr_w = $clog2(n_req);

   arb_state_t       state_q, state_d;
   logic [ptr_w-1:0] owner_q, owner_d;
   logic [ptr_w-1:0] rr_ptr_q, rr_ptr_d;
   logic [ptr_w-1:0] gnt_idx;
   logic [n_req-1:0] pick_gnt;
   logic [n_req-1:0] gnt;
   logic [n_req-1:0] rvalid_q, rvalid_d;
   logic [xlen-1:0]  rdata_q, rdata_d;
   logic [cnt_w-1:0] cnt_q [n_req];

   rr_picker #(
      .n     (n_req),
      .ptr_w (ptr_w)
   ) u_rr_picker (
      .req (bus.req),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt)
   );

   always_comb begin
      gnt            = '0;
      gnt_idx        = '0;
      state_d        = state_q;
      owner_d        = owner_q;
      rr_ptr_d       = rr_ptr_q;
      rvalid_d       = '0;
      rdata_d        = rdata_q;
      mem_read_en    = 1'b0;
      mem_write_en   = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;

      // No access is issued while reset is held, even with requests pending.
      if (rstn) begin
         if (state_q == LOCKED && bus.req[owner_q]) gnt[owner_q] = 1'b1;
         else                                       gnt          = pick_gnt;
      end

      for (int i = 0; i < n_req; i++) begin
         if (gnt[i]) begin
            gnt_idx        = ptr_w'(i);
            mem_address    = bus.addr[i*xlen +: xlen];
            mem_write_data = bus.wdata[i*xlen +: xlen];
            mem_write_en   = bus.we[i];
            mem_read_en    = ~bus.we[i];
         end
      end

      if (|gnt) begin
         rr_ptr_d = (gnt_idx == ptr_w'(n_req - 1)) ? '0 : gnt_idx + ptr_w'(1);
         if (bus.lock[gnt_idx]) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
         end else begin
            state_d = FREE;
         end
         if (!bus.we[gnt_idx]) begin
            rvalid_d[gnt_idx] = 1'b1;
            rdata_d           = mem_read_data;
         end
      end else begin
         // Locked with no grant means the owner dropped req.
         state_d = FREE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= FREE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         for (int i = 0; i < n_req; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         for (int i = 0; i < n_req; i++) begin
            if (gnt[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + cnt_w'(1);
         end
      end
   end

   always_comb begin
      grant_count = '0;
      for (int i = 0; i < n_req; i++) grant_count[i*cnt_w +: cnt_w] = cnt_q[i];
   end

   assign bus.gnt    = gnt;
   assign bus.stall  = bus.req & ~gnt;
   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: a default instance against a small
// behavioural memory, and a cnt_w=4 instance for counter saturation.
module tb_data_memory_arbiter;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   data_memory_arbiter_if #(.xlen(64), .n_req(2)) bus ();
   data_memory_arbiter_if #(.xlen(64), .n_req(2)) bus_s ();

   logic [63:0] grant_count;
   logic        mem_read_en, mem_write_en;
   logic [63:0] mem_address, mem_write_data, mem_read_data;

   logic [7:0]  grant_count_s;
   logic        mem_read_en_s, mem_write_en_s;
   logic [63:0] mem_address_s, mem_write_data_s;

   logic [63:0] mem [16];

   data_memory_arbiter #(.xlen(64), .n_req(2), .cnt_w(32)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .bus            (bus),
      .grant_count    (grant_count),
      .mem_read_en    (mem_read_en),
      .mem_write_en   (mem_write_en),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   data_memory_arbiter #(.xlen(64), .n_req(2), .cnt_w(4)) dut_sat (
      .clk            (clk),
      .rstn           (rstn),
      .bus            (bus_s),
      .grant_count    (grant_count_s),
      .mem_read_en    (mem_read_en_s),
      .mem_write_en   (mem_write_en_s),
      .mem_address    (mem_address_s),
      .mem_write_data (mem_write_data_s),
      .mem_read_data  (64'h0)
   );

   assign mem_read_data = mem[mem_address[6:3]];
   always @(posedge clk) if (mem_write_en) mem[mem_address[6:3]] <= mem_write_data;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
   endtask

   localparam logic [63:0] D0 = 64'hDEADBEEF_CAFEF00D;
   localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 64'h0;
      rstn       = 1'b0;
      bus.req    = 2'b11;
      bus.we     = 2'b00;
      bus.lock   = 2'b00;
      bus.addr   = '0;
      bus.wdata  = '0;
      bus_s.req  = 2'b00;
      bus_s.we   = 2'b00;
      bus_s.lock = 2'b00;
      bus_s.addr = '0;
      bus_s.wdata = '0;

      // reset / idle
      repeat (3) step();
      chk("rst_gnt",    bus.gnt,     2'b00);
      chk("rst_rvalid", bus.rvalid,  2'b00);
      chk("rst_rdata",  bus.rdata,   64'h0);
      chk("rst_count",  grant_count, 64'h0);
      rstn    = 1'b1;
      bus.req = 2'b00;
      #1;
      chk("idle_ren", mem_read_en,  1'b0);
      chk("idle_wen", mem_write_en, 1'b0);
      chk("idle_gnt", bus.gnt,      2'b00);

      // single write then read on port 0
      bus.req         = 2'b01;
      bus.we          = 2'b01;
      bus.addr[63:0]  = 64'h10;
      bus.wdata[63:0] = D0;
      #1;
      chk("wr_gnt",  bus.gnt,        2'b01);
      chk("wr_wen",  mem_write_en,   1'b1);
      chk("wr_addr", mem_address,    64'h10);
      chk("wr_data", mem_write_data, D0);
      step();
      bus.we = 2'b00;
      #1;
      chk("rd_gnt", bus.gnt,     2'b01);
      chk("rd_ren", mem_read_en, 1'b1);
      step();
      bus.req = 2'b00;
      #1;
      chk("rd_rvalid", bus.rvalid, 2'b01);
      chk("rd_rdata",  bus.rdata,  D0);
      step();
      chk("rd_rvalid_pulse", bus.rvalid, 2'b00);

      // contention without lock: strict alternation from rr_ptr=0
      do_reset();
      bus.req = 2'b11;
      bus.we  = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("cont_gnt",   bus.gnt,   (k % 2 == 0) ? 2'b01 : 2'b10);
         chk("cont_stall", bus.stall, (k % 2 == 0) ? 2'b10 : 2'b01);
         step();
      end
      bus.req = 2'b00;
      #1;
      chk("cont_cnt0",   grant_count[31:0],  32'd2);
      chk("cont_cnt1",   grant_count[63:32], 32'd2);
      chk("cont_rvalid", bus.rvalid,         2'b00);

      // lock burst on port 1 while port 0 waits
      do_reset();
      bus.req         = 2'b01;
      bus.we          = 2'b01;
      bus.addr[63:0]  = 64'h18;
      bus.wdata[63:0] = D1;
      #1;
      step();
      bus.req          = 2'b11;
      bus.we           = 2'b00;
      bus.lock         = 2'b10;
      bus.addr[127:64] = 64'h10;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("lock_gnt",   bus.gnt,   2'b10);
         chk("lock_stall", bus.stall, 2'b01);
         step();
         chk("lock_rvalid", bus.rvalid, 2'b10);
         chk("lock_rdata",  bus.rdata,  D0);
      end
      bus.req = 2'b01;
      #1;
      chk("release_gnt",   bus.gnt,   2'b01);
      chk("release_stall", bus.stall, 2'b00);
      step();
      chk("release_rvalid", bus.rvalid,         2'b01);
      chk("release_rdata",  bus.rdata,          D1);
      chk("lock_cnt1",      grant_count[63:32], 32'd3);
      bus.req  = 2'b00;
      bus.lock = 2'b00;

      // reset asserted during a locked port-1 read burst
      do_reset();
      bus.req = 2'b01;
      bus.we  = 2'b01;
      #1;
      step();
      bus.req  = 2'b10;
      bus.we   = 2'b00;
      bus.lock = 2'b10;
      #1;
      chk("mid_gnt", bus.gnt, 2'b10);
      step();
      chk("mid_rvalid", bus.rvalid, 2'b10);
      rstn = 1'b0;
      #1;
      chk("mid_rst_gnt", bus.gnt, 2'b00);
      step();
      chk("mid_rst_rvalid", bus.rvalid, 2'b00);
      chk("mid_rst_rdata",  bus.rdata,  64'h0);
      rstn     = 1'b1;
      bus.req  = 2'b11;
      bus.lock = 2'b00;
      #1;
      chk("mid_after_gnt", bus.gnt, 2'b01);
      step();
      bus.req = 2'b00;

      // saturation on the cnt_w=4 instance
      bus_s.req = 2'b01;
      bus_s.we  = 2'b01;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 14) chk("sat_cnt14", grant_count_s[3:0], 4'd14);
      end
      bus_s.req = 2'b00;
      #1;
      chk("sat_cnt0", grant_count_s[3:0], 4'd15);
      chk("sat_cnt1", grant_count_s[7:4], 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
